// File: rtl/mealy_stream_arbiter.sv
// Round-robin front end that time-shares one external 3-state Mealy machine:
// each granted frame is replayed LSB first and the per-bit outputs come back as one word.
module mealy_stream_arbiter #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*FRAME_W-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fsm_rst,
  output logic                    fsm_in,
  input  logic                    fsm_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [FRAME_W-1:0]      resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy,
  output logic [2:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and payloads are stable while valid waits.
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, win_id, rr_nxt;
  logic               win_found;
  logic [NREQ-1:0]    rot;
  logic [ID_W:0]      sum;
  logic [FRAME_W-1:0] win_frame, frame;
  logic [CNT_W-1:0]   k;

  // Rotate so bit 0 is rr_ptr; scanning downward leaves the nearest requester as winner.
  always_comb begin
    rot       = NREQ'({req_valid, req_valid} >> rr_ptr);
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        win_found = 1'b1;
        sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
        win_id = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_frame = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == ID_W'(i)) win_frame = req_data[i*FRAME_W +: FRAME_W];
    end
  end

  assign rr_nxt = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req_valid) state_nxt = S_GRANT;
      S_GRANT: state_nxt = win_found ? S_SHIFT : S_IDLE;
      S_SHIFT: if (k == K_LAST) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      k         <= '0;
      frame     <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_GRANT: begin
          if (win_found) begin
            frame   <= win_frame;
            resp_id <= win_id;
            rr_ptr  <= rr_nxt;
          end
          k <= '0;
        end
        S_SHIFT: begin
          // Machine output is registered, so bit k-1's result is visible while bit k is driven.
          if (k != '0) resp_data[k - 1'b1] <= fsm_out;
          k <= k + 1'b1;
        end
        S_DRAIN: resp_data[FRAME_W-1] <= fsm_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == S_GRANT) && win_found && !reset && (win_id == ID_W'(i));
    end
  end

  assign fsm_rst    = reset || (state == S_GRANT);
  assign fsm_in     = (state == S_SHIFT) && !reset && frame[k];
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Bench for mealy_stream_arbiter: emulates the shared Mealy machine, drives requesters,
// and checks every cycle against a timing/arbitration model built from the block's rules.
module tb_mealy_stream_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 8;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*FW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               fsm_rst, fsm_in;
  logic               fsm_out = 1'b0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [FW-1:0]      resp_data;
  logic [IDW-1:0]     resp_id;
  logic               busy;
  logic [2:0]         state_dbg;

  mealy_stream_arbiter #(.NREQ(NREQ), .FRAME_W(FW), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fsm_rst(fsm_rst), .fsm_in(fsm_in), .fsm_out(fsm_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy), .state_dbg(state_dbg)
  );

  // Machine tables indexed [state][input]: S0 0->S1/1 1->S2/0, S1 0->S2/0 1->S0/1, S2 0->S1/1 1->S2/0
  int mn [3][2] = '{'{1, 2}, '{2, 0}, '{1, 2}};
  int mo [3][2] = '{'{1, 0}, '{0, 1}, '{1, 0}};

  // ---------------- shared Mealy machine (environment) ----------------
  int m_st = 0;
  always @(posedge clk) begin
    if (fsm_rst) begin
      m_st    <= 0;
      fsm_out <= 1'b0;
    end else begin
      fsm_out <= mo[m_st][fsm_in] != 0;
      m_st    <= mn[m_st][fsm_in];
    end
  end

  // ---------------- bookkeeping ----------------
  int tot = 0, bad = 0, cyc = 0;
  int tb_rr = 0, gcyc = 0, rst_pulses = 0;
  bit in_flight = 0, m_grant_next = 0;
  logic [FW-1:0]  cur_frame = '0;
  logic [FW-1:0]  exp_q[$];
  logic [IDW-1:0] id_q[$];
  int grant_log[$];
  logic [FW-1:0]  last_resp_data = '0;
  int last_resp_id = -1, last_hs_cyc = 0, last_grant_cyc = 0, last_gap = 0;

  // driver controls
  bit next_reset = 1, next_resp_ready = 0, refill = 0;
  logic [NREQ-1:0] new_mask = '0, acc = '0;
  logic [FW-1:0]   new_frame [NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] mealy_ref(input logic [FW-1:0] f);
    int s = 0;
    logic [FW-1:0] r = '0;
    for (int b = 0; b < FW; b++) begin
      r[b] = mo[s][f[b]] != 0;
      s    = mn[s][f[b]];
    end
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(rr + i) % NREQ]) return (rr + i) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- scoreboard / per-cycle model ----------------
  task automatic monitor();
    logic [NREQ-1:0] exp_rdy;
    logic [FW-1:0]   sh;
    int w, off;
    bit exp_grant, exp_in, exp_rv, idle_now;
    if (reset) begin
      check("rst_fsm_rst", fsm_rst, 1);
      check("rst_req_ready", req_ready, 0);
      in_flight = 0; m_grant_next = 0; tb_rr = 0; acc = '0;
      exp_q.delete(); id_q.delete();
      return;
    end
    exp_grant = m_grant_next;
    exp_rdy = '0;
    w = -1;
    if (exp_grant) begin
      w = pick(req_valid, tb_rr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    check("fsm_rst", fsm_rst, exp_grant);
    if (fsm_rst) rst_pulses++;
    acc = req_ready;
    if (exp_grant && w >= 0) begin
      cur_frame = req_data[w*FW +: FW];
      exp_q.push_back(mealy_ref(cur_frame));
      id_q.push_back(IDW'(w));
      grant_log.push_back(w);
      last_gap = cyc - last_hs_cyc;
      gcyc = cyc; last_grant_cyc = cyc;
      in_flight = 1;
      tb_rr = (w + 1) % NREQ;
    end
    idle_now = !in_flight;
    off = cyc - gcyc;
    exp_in = 0;
    if (in_flight && off >= 1 && off <= FW) begin
      sh = cur_frame >> (off - 1);
      exp_in = sh[0];
    end
    check("fsm_in", fsm_in, exp_in);
    check("busy", busy, in_flight);
    exp_rv = in_flight && off >= FW + 2;
    check("resp_valid", resp_valid, exp_rv);
    if (exp_rv && exp_q.size() > 0) begin
      check("resp_data", resp_data, exp_q[0]);
      check("resp_id", resp_id, id_q[0]);
      if (resp_ready) begin
        last_resp_data = resp_data;
        last_resp_id   = resp_id;
        last_hs_cyc    = cyc;
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        in_flight = 0;
      end
    end
    m_grant_next = idle_now && (req_valid != '0);
    if (refill) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin new_mask[i] = 1'b1; new_frame[i] = FW'($urandom); end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    reset = next_reset;
    for (int i = 0; i < NREQ; i++) if (acc[i]) req_valid[i] = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (new_mask[i] && !req_valid[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*FW +: FW] = new_frame[i];
      end
    end
    new_mask = '0;
    acc = '0;
    resp_ready = next_resp_ready;
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic request(input int i, input logic [FW-1:0] f);
    new_mask[i] = 1'b1;
    new_frame[i] = f;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step();
    while ((in_flight || m_grant_next || req_valid != '0 || new_mask != '0) && n < budget) begin
      step();
      n++;
    end
    if (in_flight || m_grant_next || req_valid != '0) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    step();
    while (last_grant_cyc != cyc && n < budget) begin
      step();
      n++;
    end
    if (last_grant_cyc != cyc) check("grant_timeout", 1, 0);
  endtask

  task automatic do_reset(input int cycles);
    next_reset = 1;
    repeat (cycles) step();
    next_reset = 0;
    step();
  endtask

  // ---------------- stimulus ----------------
  int t3_exp [5] = '{0, 1, 2, 3, 0};
  int base, p, n;
  logic [FW-1:0] held_data;

  initial begin
    for (int i = 0; i < NREQ; i++) new_frame[i] = '0;
    do_reset(3);
    check("reset_resp_data", resp_data, 0);
    check("reset_resp_id", resp_id, 0);
    check("reset_busy", busy, 0);
    check("reset_resp_valid", resp_valid, 0);

    // single frame
    next_resp_ready = 1;
    request(0, 8'h93);
    wait_idle(60);
    check("t1_data", last_resp_data, 8'h24);
    check("t1_id", last_resp_id, 0);
    check("t1_latency", last_hs_cyc - last_grant_cyc, FW + 2);

    // constant patterns and one fsm_rst pulse per frame
    p = rst_pulses;
    request(1, 8'h00);
    wait_idle(60);
    check("t2_zeros", last_resp_data, 8'h55);
    request(2, 8'hFF);
    wait_idle(60);
    check("t2_ones", last_resp_data, 8'h00);
    check("t2_rst_pulses", rst_pulses - p, 2);

    // round robin with all requesters held
    do_reset(2);
    base = grant_log.size();
    refill = 1;
    for (int i = 0; i < NREQ; i++) request(i, FW'($urandom));
    n = 0;
    while (grant_log.size() < base + 5 && n < 200) begin step(); n++; end
    refill = 0;
    wait_idle(200);
    if (grant_log.size() < base + 5) check("t3_grant_count", grant_log.size() - base, 5);
    else for (int j = 0; j < 5; j++) check("t3_order", grant_log[base + j], t3_exp[j]);

    // back-pressure in DONE with another requester waiting
    next_resp_ready = 0;
    request(0, FW'($urandom));
    request(1, FW'($urandom));
    n = 0;
    step();
    while (!resp_valid && n < 60) begin step(); n++; end
    check("t4_resp_valid", resp_valid, 1);
    base = grant_log.size();
    held_data = resp_data;
    repeat (5) step();
    check("t4_held_data", resp_data, held_data);
    check("t4_busy", busy, 1);
    check("t4_no_grant", grant_log.size() - base, 0);
    next_resp_ready = 1;
    wait_idle(200);
    check("t4_next_grant", grant_log.size() - base, 1);

    // reset in the middle of SHIFT (k=3), then requesters 1 and 3 together
    request(2, FW'($urandom));
    wait_grant(40);
    repeat (3) step();
    next_reset = 1;
    step();
    next_reset = 0;
    request(1, FW'($urandom));
    request(3, FW'($urandom));
    step();
    check("t5_busy", busy, 0);
    check("t5_resp_valid", resp_valid, 0);
    wait_idle(200);
    check("t5_first", grant_log[grant_log.size() - 2], 1);
    check("t5_second", grant_log[grant_log.size() - 1], 3);

    // late arrival during another frame's SHIFT
    request(0, FW'($urandom));
    wait_grant(40);
    repeat (2) step();
    request(2, FW'($urandom));
    wait_idle(200);
    check("t6_order", grant_log[grant_log.size() - 1], 2);
    check("t6_gap", last_gap, 2);

    // randomized traffic with back-pressure and rare resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r = $urandom_range(0, NREQ - 1);
        if (!req_valid[r] && !new_mask[r]) request(r, FW'($urandom));
      end
      next_resp_ready = ($urandom_range(0, 3) != 0);
      next_reset = ($urandom_range(0, 599) == 0);
      step();
    end
    next_reset = 0;
    next_resp_ready = 1;
    wait_idle(500);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
